// File: rtl/arm_pkg.sv
// Shared fetch front-end definitions: request FSM state encoding, default reset vector
// and the width of one prefetch queue entry.
package arm_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

   // Queue entry layout: {instruction word, fetch address}.
   localparam int unsigned ENTRY_W = 64;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {instr, addr}. Flush has priority over push and pop.
// DEPTH must be a power of two so that the pointers wrap naturally.
module fetch_fifo
   import arm_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic               i_flush,
   input  logic [ENTRY_W-1:0] i_data,
   output logic [ENTRY_W-1:0] o_head,
   output logic [CW-1:0]      o_count
);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_head;
   logic [AW-1:0]      r_tail;
   logic [CW-1:0]      r_count;
   logic               w_do_pop;

   assign w_do_pop = i_pop && (r_count != '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_do_pop) begin
            r_head <= r_head + 1'b1;
         end
         case ({i_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; the top gates the head outputs while the queue is empty.
   always_ff @(posedge i_clk) begin
      if (i_push && !i_flush) begin
         r_mem[r_tail] <= i_data;
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding-request FSM, fetch PC and prefetch queue.
// Build option FETCH_PERF_CNT_EN adds fetch_cnt / flush_cnt performance counters.
//
//   state | meaning
//   RUN   | no request outstanding; issue one when the queue has room
//   WAIT  | request outstanding, its response will be queued
//   DROP  | request outstanding, its response belongs to a flushed path
module fetch_unit
   import arm_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] PCPlus8,
   input  logic        PCSrc,
   input  logic [31:0] branch_target
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] flush_cnt
`endif
);

   localparam int            CW   = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_state_t       r_state;
   logic [31:0]        r_fetch_pc;
   logic [31:0]        r_req_addr;
   logic               r_req;
   logic [CW-1:0]      w_count;
   logic [ENTRY_W-1:0] w_head;
   logic               w_push;
   logic               w_pop;
   logic               w_has_room;

   assign w_has_room  = (w_count < FULL);
   assign instr_valid = (w_count != '0);
   assign w_pop       = instr_valid && instr_ready && !PCSrc;
   assign w_push      = (r_state == WAIT) && imem_rvalid && !PCSrc;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (PCSrc),
      .i_data  ({imem_rdata, r_req_addr}),
      .o_head  (w_head),
      .o_count (w_count)
   );

   // Room is checked at request time, so a response can always be queued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= RUN;
         r_fetch_pc <= RESET_VEC;
         r_req_addr <= RESET_VEC;
         r_req      <= 1'b0;
      end else begin
         r_req <= 1'b0;
         if (PCSrc) begin
            r_fetch_pc <= {branch_target[31:2], 2'b00};
         end
         case (r_state)
            RUN: begin
               if (!PCSrc && w_has_room) begin
                  r_req      <= 1'b1;
                  r_req_addr <= r_fetch_pc;
                  r_fetch_pc <= r_fetch_pc + 32'd4;
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  r_state <= RUN;
               end else if (PCSrc) begin
                  r_state <= DROP;
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  r_state <= RUN;
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign imem_req  = r_req;
   assign imem_addr = r_req_addr;
   assign Instr     = instr_valid ? w_head[63:32] : 32'd0;
   assign PCPlus8   = (instr_valid ? w_head[31:0] : 32'd0) + 32'd8;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_push) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (PCSrc) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
      end
   end

   assign fetch_cnt = r_fetch_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request, one cycle per request.
REQ-006 SHALL have port imem_addr  output  32  word-aligned request address, valid with imem_req.
REQ-007 SHALL have port imem_rvalid  input  1  read data valid, one pulse per accepted request, latency >= 1 cycle.
REQ-008 SHALL have port imem_rdata  input  32  read data, valid with imem_rvalid.
REQ-009 SHALL have port Instr  output  32  head-of-queue instruction to the decode/controller stage.
REQ-010 SHALL have port instr_valid  output  1  Instr and PCPlus8 valid.
REQ-011 SHALL have port instr_ready  input  1  consumer accepts head entry this cycle.
REQ-012 SHALL have port PCPlus8  output  32  address of head entry plus 8.
REQ-013 SHALL have port PCSrc  input  1  redirect (branch or PC write) this cycle.
REQ-014 SHALL have port branch_target  input  32  redirect address, bits [1:0] ignored.

Function
REQ-015 SHALL keep at most one memory request outstanding.
REQ-016 SHALL use FSM states RUN (no request outstanding), WAIT (request outstanding, response kept), DROP (request outstanding, response discarded).
REQ-017 SHALL, in RUN with count < DEPTH and PCSrc low, assert imem_req with imem_addr = fetch_pc, advance fetch_pc by 4, and enter WAIT.
REQ-018 SHALL, in WAIT on imem_rvalid, push {imem_rdata, request address} into the queue and return to RUN; next imem_req no earlier than the following cycle.
REQ-019 SHALL present the head entry combinationally: instr_valid = (count != 0), Instr = head data, PCPlus8 = head address + 8.
REQ-020 SHALL pop the head on a rising edge where instr_valid && instr_ready && !PCSrc.
REQ-021 SHALL allow push and pop on the same edge, count unchanged; push is never presented while full (space is reserved at request time).
REQ-022 SHALL, on PCSrc high: empty the queue, load fetch_pc <= {branch_target[31:2], 2'b00}, suppress imem_req that cycle, ignore instr_ready; flush has priority over push and pop.
REQ-023 SHALL, on PCSrc in WAIT without imem_rvalid, enter DROP; with imem_rvalid the same cycle, discard the data and enter RUN.
REQ-024 SHALL, in DROP, discard the next imem_rvalid data and enter RUN; a further PCSrc in DROP only updates fetch_pc.
REQ-025 SHALL wrap head/tail pointers modulo DEPTH; fetch_pc wraps modulo 2^32.

Reset
REQ-026 SHALL, while reset is low, asynchronously force state RUN, count 0, pointers 0, fetch_pc RESET_VEC, imem_req 0, instr_valid 0.
REQ-027 SHALL drive imem_addr = RESET_VEC, Instr = 0, PCPlus8 = 8 while empty after reset; first imem_req on the first rising edge after reset deasserts.
REQ-028 SHALL, on reset mid-request, abandon the outstanding request; any imem_rvalid arriving in RUN SHALL be ignored.

Configuration
REQ-029 SHALL, with FETCH_PERF_CNT_EN defined, add outputs fetch_cnt (32, increments per pushed instruction) and flush_cnt (32, increments per PCSrc cycle), both reset to 0 and wrapping.
REQ-030 SHALL, without FETCH_PERF_CNT_EN, omit both ports and counters; all other behaviour identical.

Structure
REQ-031 SHALL place the FSM state enum (RUN, WAIT, DROP) and RESET_VEC default in shared package arm_pkg.
REQ-032 SHALL implement the queue as sub-module fetch_fifo (DEPTH x 64 bits, push/pop/flush, count output); FSM and fetch_pc reside in fetch_unit.

Verification
REQ-033 SHALL cover reset then 1-cycle memory, instr_ready=1: imem_addr sequence 0,4,8,C; Instr matches memory; PCPlus8 = 8,C,10,14.
REQ-034 SHALL cover instr_ready=0 for 20 cycles: exactly 4 requests, count=4, no imem_req while full; on release 4 pops then fetch resumes at 0x10.
REQ-035 SHALL cover PCSrc=1 with branch_target=0x100 while 3 entries queued and one outstanding: queue empties, stale response dropped, next imem_addr=0x100, first Instr from 0x100, PCPlus8=0x108.
REQ-036 SHALL cover PCSrc coinciding with imem_rvalid: data discarded, state RUN, next request to target.
REQ-037 SHALL cover reset low asserted during WAIT: outputs reset immediately, late imem_rvalid ignored, fetch restarts at RESET_VEC.
REQ-038 SHALL cover FETCH_PERF_CNT_EN build: 10 pushes and 2 flushes -> fetch_cnt=10, flush_cnt=2.
